// File: rtl/core_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package core_pkg;

    localparam int unsigned PCIncrAmt = 4;
    localparam logic [31:0] PCInit    = 32'h0;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with push, pop and single-cycle flush.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Instruction-fetch front end: PC sequencing, req/ack I-memory fetch,
// prefetch queue and redirect handling with in-flight discard.
module ifetch_prefetch_unit
    import core_pkg::*;
#(
    parameter int              DEPTH   = 4,
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] PC_INIT = XLEN'(PCInit),
    parameter int              PC_INCR = PCIncrAmt
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemAck,
    input  logic [XLEN-1:0] IMemData,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    input  logic            Stall,
    output logic            IF_Valid,
    output logic [XLEN-1:0] IF_Instruction,
    output logic [XLEN-1:0] IF_PCAdd4
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pending_pc;
    logic            outstanding;

    logic [2*XLEN-1:0] head;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              ack_fire;

    assign ack_fire   = outstanding && IMemAck;
    assign pop        = !empty && !Stall && !Redirect;
    assign push       = ack_fire && (state == FETCH) && !Redirect && (!full || pop);
    assign count_next = Redirect ? '0 : (count - CW'(pop));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push),
        .pop   (pop),
        .flush (Redirect),
        .wdata ({IMemData, IMemAddr}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // The request register doubles as the outstanding flag; it always drops
    // for one cycle after an ack, which bounds the issue rate.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= FETCH;
            fetch_pc    <= PC_INIT;
            pending_pc  <= PC_INIT;
            outstanding <= 1'b0;
        end else begin
            if (outstanding) outstanding <= !IMemAck;
            else             outstanding <= (count_next < CW'(DEPTH));

            unique case (state)
                FETCH: begin
                    if (Redirect) begin
                        if (outstanding && !IMemAck) begin
                            state      <= DISCARD;
                            pending_pc <= RedirectPC;
                        end else begin
                            fetch_pc <= RedirectPC;
                        end
                    end else if (ack_fire) begin
                        fetch_pc <= fetch_pc + XLEN'(PC_INCR);
                    end
                end
                DISCARD: begin
                    if (IMemAck) begin
                        state    <= FETCH;
                        fetch_pc <= Redirect ? RedirectPC : pending_pc;
                    end else if (Redirect) begin
                        pending_pc <= RedirectPC;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign IMemReq        = outstanding;
    assign IMemAddr       = fetch_pc;
    assign IF_Valid       = !empty;
    assign IF_Instruction = IF_Valid ? head[2*XLEN-1:XLEN] : '0;
    assign IF_PCAdd4      = IF_Valid ? (head[XLEN-1:0] + XLEN'(PC_INCR)) : '0;

endmodule
